// File: rtl/uart_rx_push.sv
// uart_rx_push: UART receive front end (8N1 / 8E1 / 8O1) that pushes every
// good byte into the downstream byte FIFO through its wr/din/full port.
// Framing and parity errors discard the byte and raise a one-cycle flag.
// Good bytes that meet a full FIFO are dropped, flagged and counted.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle, waiting for rxd_s to fall
// START  | half-bit wait, then confirm the start bit (high = false start)
// DATA   | eight full-bit waits, LSB first into the shift register
// PARITY | one full-bit wait, capture the parity bit (PARITY_EN only)
// STOP   | one full-bit wait, sample stop bit and make the push decision
// BREAK  | stop bit was low, wait for the line to return high
module uart_rx_push #(
    parameter int CLK_DIV    = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       full,
    output logic       wr,
    output logic [7:0] din,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic [7:0] drop_cnt
);

    localparam int CW = $clog2(CLK_DIV);
    // The first wait ends in the middle of the start bit; every later wait
    // is one full bit so all samples land mid-bit.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rxd_s_q, rxd_s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_bit_q, par_bit_d;
    logic          wr_q, wr_d;
    logic [7:0]    din_q, din_d;
    logic          frame_err_q, frame_err_d;
    logic          parity_err_q, parity_err_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          tick;
    logic          par_bad;

    // Bit timer has expired: this cycle is a sample point.
    assign tick = (cnt_q == '0);

    // Data bits plus parity bit must XOR to PARITY_ODD; disabled parity never errs.
    assign par_bad = PARITY_EN && ((^shift_q ^ par_bit_q) != PARITY_ODD);

    // Two-flop synchronizer for the asynchronous serial pin.
    always_comb begin
        sync1_d = rxd;
        rxd_s_d = sync1_q;
    end

    // Next-state, bit timing, shift register and push/error decision.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        wr_d         = 1'b0;
        din_d        = din_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        drop_cnt_d   = drop_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (!rxd_s_q) begin
                    cnt_d   = HALF_LOAD;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (tick) begin
                    if (rxd_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d     = FULL_LOAD;
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DATA: begin
                if (tick) begin
                    shift_d = {rxd_s_q, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_PARITY: begin
                if (tick) begin
                    par_bit_d = rxd_s_q;
                    cnt_d     = FULL_LOAD;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_STOP: begin
                if (tick) begin
                    if (!rxd_s_q) begin
                        // Framing and parity errors may be reported together.
                        frame_err_d  = 1'b1;
                        parity_err_d = par_bad;
                        state_d      = S_BREAK;
                    end else if (par_bad) begin
                        parity_err_d = 1'b1;
                        state_d      = S_IDLE;
                    end else if (full) begin
                        // Sole writer: full cannot rise before the wr cycle,
                        // so deciding on this cycle's full is safe.
                        overrun_d = 1'b1;
                        if (drop_cnt_q != 8'hFF) begin
                            drop_cnt_d = drop_cnt_q + 8'd1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        wr_d    = 1'b1;
                        din_d   = shift_q;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_BREAK: begin
                if (rxd_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rxd_s_q      <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_bit_q    <= 1'b0;
            wr_q         <= 1'b0;
            din_q        <= 8'h00;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            drop_cnt_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rxd_s_q      <= rxd_s_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            wr_q         <= wr_d;
            din_q        <= din_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign wr         = wr_q;
    assign din        = din_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
